// File: rtl/evm_pkg.sv
// Shared definitions for the voting-machine lock sequencing logic.
package evm_pkg;
  localparam int CODE_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    CLR,
    SHIFT,
    WAIT,
    OPEN,
    FAIL,
    LOCKOUT
  } state_t;
endpackage

// File: rtl/cycle_timer.sv
// Loadable down-counter; done is high while the count sits at zero.
// Latency: load takes effect on the next edge; no backpressure.
module cycle_timer #(
  parameter int W = 4
) (
  input  logic         clock,
  input  logic         Reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         done
);
  logic [W-1:0] cnt;

  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (en && cnt != '0) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);
endmodule

// File: rtl/lock_access_controller.sv
// Drives the serial lock with a parallel code, then opens a vote window or counts a failure.
// Latency: verdict visible 7 cycles after code_valid; no backpressure, code_valid outside IDLE is dropped.
module lock_access_controller
  import evm_pkg::*;
#(
  parameter int MAX_FAILS      = 3,
  parameter int UNLOCK_CYCLES  = 16,
  parameter int LOCKOUT_CYCLES = 32,
  parameter int RESP_TIMEOUT   = 4
) (
  input  logic              clock,
  input  logic              Reset_n,
  input  logic [CODE_W-1:0] code_in,
  input  logic              code_valid,
  input  logic              vote_done,
  input  logic              lock_Correct,
  input  logic              lock_Incorrect,
  output logic              lock_rst,
  output logic              lock_B,
  output logic              busy,
  output logic              vote_enable,
  output logic              fail_pulse,
  output logic              lockout,
  output logic [3:0]        fail_count
);
  localparam int OPEN_W = $clog2(UNLOCK_CYCLES) + 1;
  localparam int LOCK_W = $clog2(LOCKOUT_CYCLES) + 1;
  localparam int RESP_W = $clog2(RESP_TIMEOUT) + 1;
  localparam int IDX_W  = $clog2(CODE_W);

  state_t             state;
  logic [CODE_W-1:0]  code;
  logic [IDX_W-1:0]   bit_idx;
  logic [IDX_W-1:0]   nxt_idx;
  logic [3:0]         fail_inc;
  logic               open_done;
  logic               lock_done;
  logic               resp_done;

  assign nxt_idx  = bit_idx - 1'b1;
  assign fail_inc = (fail_count == 4'hF) ? 4'hF : fail_count + 4'd1;

  // Each timer is held loaded outside its own state, so it starts fresh on entry.
  cycle_timer #(.W(OPEN_W)) u_open_timer (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .load     (state != OPEN),
    .en       (state == OPEN),
    .load_val (OPEN_W'(UNLOCK_CYCLES - 1)),
    .done     (open_done)
  );

  cycle_timer #(.W(LOCK_W)) u_lockout_timer (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .load     (state != LOCKOUT),
    .en       (state == LOCKOUT),
    .load_val (LOCK_W'(LOCKOUT_CYCLES - 1)),
    .done     (lock_done)
  );

  cycle_timer #(.W(RESP_W)) u_resp_timer (
    .clock    (clock),
    .Reset_n  (Reset_n),
    .load     (state != WAIT),
    .en       (state == WAIT),
    .load_val (RESP_W'(RESP_TIMEOUT - 1)),
    .done     (resp_done)
  );

  // Outputs are assigned alongside the next state so they line up with it cycle for cycle.
  always_ff @(posedge clock or negedge Reset_n) begin
    if (!Reset_n) begin
      state       <= IDLE;
      code        <= '0;
      bit_idx     <= '0;
      fail_count  <= '0;
      lock_rst    <= 1'b0;
      lock_B      <= 1'b0;
      busy        <= 1'b0;
      vote_enable <= 1'b0;
      fail_pulse  <= 1'b0;
      lockout     <= 1'b0;
    end else begin
      lock_rst   <= 1'b0;
      lock_B     <= 1'b0;
      fail_pulse <= 1'b0;
      case (state)
        IDLE: begin
          if (code_valid) begin
            code     <= code_in;
            state    <= CLR;
            lock_rst <= 1'b1;
            busy     <= 1'b1;
          end
        end
        CLR: begin
          state   <= SHIFT;
          bit_idx <= IDX_W'(CODE_W - 1);
          lock_B  <= code[CODE_W-1];
        end
        SHIFT: begin
          if (bit_idx == '0) begin
            state <= WAIT;
          end else begin
            bit_idx <= nxt_idx;
            lock_B  <= code[nxt_idx];
          end
        end
        WAIT: begin
          // Incorrect wins when both verdicts are raised together.
          if (lock_Incorrect || (!lock_Correct && resp_done)) begin
            state      <= FAIL;
            fail_pulse <= 1'b1;
            fail_count <= fail_inc;
          end else if (lock_Correct) begin
            state       <= OPEN;
            vote_enable <= 1'b1;
            fail_count  <= '0;
          end
        end
        OPEN: begin
          if (vote_done || open_done) begin
            state       <= IDLE;
            vote_enable <= 1'b0;
            busy        <= 1'b0;
          end
        end
        FAIL: begin
          if (fail_count >= 4'(MAX_FAILS)) begin
            state   <= LOCKOUT;
            lockout <= 1'b1;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end
        LOCKOUT: begin
          if (lock_done) begin
            state      <= IDLE;
            lockout    <= 1'b0;
            busy       <= 1'b0;
            fail_count <= '0;
          end
        end
        default: begin
          state       <= IDLE;
          busy        <= 1'b0;
          vote_enable <= 1'b0;
          lockout     <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: doc/lock_access_controller.md
Name: lock_access_controller

Overview:
- Sequences the serial `lock` FSM for the voting machine.
- Accepts a 4-bit access code in parallel, clears the lock, then shifts the code into it MSB-first. It waits for the lock's Correct/Incorrect verdict and opens a timed voting window on success.
- Counts consecutive failed attempts and enforces a timed lockout after too many failures.
- Sits between the front-panel code entry and the ballot logic; `vote_enable` gates the vote counters.

Parameters:
- MAX_FAILS, 3, consecutive failed attempts that trigger lockout (1..15).
- UNLOCK_CYCLES, 16, length of the voting window in clock cycles (>=1).
- LOCKOUT_CYCLES, 32, length of the lockout period in clock cycles (>=1).
- RESP_TIMEOUT, 4, cycles to wait in WAIT for a lock verdict before declaring failure (>=1).

Ports:
- clock  in  1  system clock; all state on rising edge.
- Reset_n  in  1  asynchronous, active-low reset.
- code_in  in  4  access code, sampled only when code_valid=1 in IDLE.
- code_valid  in  1  one-cycle request to attempt an unlock.
- vote_done  in  1  pulse from ballot logic; closes the voting window early.
- lock_Correct  in  1  Correct output of lock.
- lock_Incorrect  in  1  Incorrect output of lock.
- lock_rst  out  1  registered active-high reset to the lock's Reset.
- lock_B  out  1  registered serial bit to the lock's B.
- busy  out  1  high in every state except IDLE.
- vote_enable  out  1  high throughout OPEN.
- fail_pulse  out  1  one-cycle pulse per failed attempt.
- lockout  out  1  high throughout LOCKOUT.
- fail_count  out  4  consecutive failed attempts so far.

Behaviour:
- Reset (Reset_n low, asynchronous): state=IDLE. All outputs 0; fail_count=0; all timers 0.
- All outputs are registered and decoded from the state and counters.
- States and transitions:
  - IDLE: code_valid=1 → latch code_in, go to CLR. code_valid is ignored in every other state and is not queued.
  - CLR: 1 cycle with lock_rst=1, lock_B=0. Then go to SHIFT with bit index 3.
  - SHIFT: 4 cycles; lock_B = code[3], code[2], code[1], code[0] in turn. Then go to WAIT.
  - WAIT: lock_B=0. lock_Correct=1 → OPEN. lock_Incorrect=1 → FAIL. Neither for RESP_TIMEOUT cycles → FAIL. Both high together → treated as Incorrect.
  - OPEN: vote_enable=1 for UNLOCK_CYCLES cycles, then IDLE. vote_done=1 exits to IDLE at the next edge. vote_done on the final timer cycle still yields exactly one exit. fail_count cleared on entry.
  - FAIL: 1 cycle with fail_pulse=1; fail_count increments, saturating at 15. If the new count >= MAX_FAILS → LOCKOUT, else → IDLE.
  - LOCKOUT: lockout=1 for LOCKOUT_CYCLES cycles, then IDLE with fail_count cleared.
- Latency with code_valid sampled at edge 0:
  - Cycle 1: CLR.
  - Cycles 2-5: SHIFT.
  - Cycle 6: WAIT; the lock reports its verdict in this cycle.
  - Cycle 7: first cycle of OPEN or FAIL.
- vote_done outside OPEN has no effect.
- Reset asserted mid-operation forces IDLE immediately, which also aborts an open window or a lockout.
- Timer widths are $clog2 of each parameter plus 1; down-counters load on state entry.

Decomposition:
- Shared package `evm_pkg`: state enum (IDLE, CLR, SHIFT, WAIT, OPEN, FAIL, LOCKOUT) and the code width constant (4).
- One natural sub-module: `cycle_timer` (load value, enable, done flag), instantiated for the OPEN, LOCKOUT and WAIT timeouts.
- The controller is tested against the real `lock` instance.

Test Plan:
- Correct code: code_in=4'b1010, code_valid at edge 0 → lock_rst=1 in cycle 1; lock_B=1,0,1,0 in cycles 2-5; vote_enable=1 in cycles 7..22 (16 cycles); fail_count=0.
- Wrong code: code_in=4'b0110 → fail_pulse=1 in cycle 7 only; fail_count=1; busy=0 from cycle 8.
- Lockout: three consecutive wrong codes → third attempt gives fail_count=3 and lockout=1 for 32 cycles. A code_valid with 4'b1010 during lockout is ignored. Afterwards fail_count=0 and 4'b1010 then unlocks.
- Early close: correct code, vote_done pulsed in the 3rd cycle of OPEN → vote_enable=0 on the next cycle; a fresh code_valid is accepted immediately.
- Timeout/priority: lock verdicts forced to 0 → FAIL after 4 WAIT cycles. Both verdicts forced high → FAIL. code_valid pulsed during SHIFT → no effect.
- Reset mid-window: Reset_n low in OPEN → vote_enable, busy, fail_count all 0 asynchronously; IDLE on release.
